// File: rtl/dio_interlock_ctrl.sv
// Digital-I/O interlock core: 2-FF synchronisers, per-bit debounce, masked sticky
// interlock latching and a trip/clear/recover FSM that forces a safe DO pattern.
module dio_interlock_ctrl #(
    parameter int DI_W    = 8,
    parameter int DO_W    = 8,
    parameter int IL_W    = 8,
    parameter int DEB_W   = 16,
    parameter int HOLDOFF = 1000
) (
    input  logic              s00_axi_aclk,
    input  logic              s00_axi_aresetn,
    input  logic [DI_W-1:0]   i_di,
    input  logic [IL_W-1:0]   i_interlock,
    input  logic [DEB_W-1:0]  i_deb_cnt,
    input  logic [IL_W-1:0]   i_il_mask,
    input  logic [DO_W-1:0]   i_do,
    input  logic [DO_W-1:0]   i_safe_do,
    input  logic              i_il_clr,
    output logic [DI_W-1:0]   o_di,
    output logic [DO_W-1:0]   o_do,
    output logic [IL_W-1:0]   o_il_latch,
    output logic [1:0]        o_il_state,
    output logic              o_tripped
);

    localparam int HO_W = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;

    typedef enum logic [1:0] {
        ST_NORMAL  = 2'b00,
        ST_TRIPPED = 2'b01,
        ST_RECOVER = 2'b10
    } state_e;

    logic [DI_W-1:0]  di_meta_q, di_sync_q, di_filt_q, di_filt_d;
    logic [IL_W-1:0]  il_meta_q, il_sync_q, il_filt_q, il_filt_d;
    logic [DEB_W-1:0] di_cnt_q [DI_W];
    logic [DEB_W-1:0] di_cnt_d [DI_W];
    logic [DEB_W-1:0] il_cnt_q [IL_W];
    logic [DEB_W-1:0] il_cnt_d [IL_W];

    logic [IL_W-1:0]  latch_q, latch_d;
    logic [IL_W-1:0]  active;
    state_e           state_q, state_d;
    logic [HO_W-1:0]  ho_cnt_q, ho_cnt_d;
    logic [DO_W-1:0]  do_q;
    logic             tripped_q;

    logic [DEB_W-1:0] deb_thr;
    logic [DEB_W:0]   deb_thr_ext;

    // One debounce step for a single bit; returns {new_filt, new_cnt}.
    function automatic logic [DEB_W:0] deb_step(
        input logic             sync,
        input logic             filt,
        input logic [DEB_W-1:0] cnt,
        input logic [DEB_W:0]   thr
    );
        logic [DEB_W:0] cnt_inc;
        cnt_inc = {1'b0, cnt} + {{DEB_W{1'b0}}, 1'b1};
        if (sync == filt) begin
            deb_step = {filt, {DEB_W{1'b0}}};
        end else if (cnt_inc >= thr) begin
            deb_step = {sync, {DEB_W{1'b0}}};
        end else begin
            deb_step = {filt, cnt_inc[DEB_W-1:0]};
        end
    endfunction

    assign deb_thr     = (i_deb_cnt == '0) ? {{(DEB_W-1){1'b0}}, 1'b1} : i_deb_cnt;
    assign deb_thr_ext = {1'b0, deb_thr};

    always_comb begin
        di_filt_d = di_filt_q;
        il_filt_d = il_filt_q;
        for (int i = 0; i < DI_W; i++) begin
            di_cnt_d[i] = '0;
            {di_filt_d[i], di_cnt_d[i]} = deb_step(di_sync_q[i], di_filt_q[i], di_cnt_q[i], deb_thr_ext);
        end
        for (int i = 0; i < IL_W; i++) begin
            il_cnt_d[i] = '0;
            {il_filt_d[i], il_cnt_d[i]} = deb_step(il_sync_q[i], il_filt_q[i], il_cnt_q[i], deb_thr_ext);
        end
    end

    assign active = il_filt_q & i_il_mask;

    // A clear rebuilds the latch from what is still active so live faults stay visible.
    assign latch_d = i_il_clr ? active : (latch_q | active);

    always_comb begin
        state_d  = state_q;
        ho_cnt_d = ho_cnt_q;
        case (state_q)
            ST_NORMAL: begin
                if (|active) state_d = ST_TRIPPED;
            end
            ST_TRIPPED: begin
                if (i_il_clr && (active == '0)) begin
                    state_d  = ST_RECOVER;
                    ho_cnt_d = '0;
                end
            end
            ST_RECOVER: begin
                if (|active) begin
                    state_d = ST_TRIPPED;
                end else if (ho_cnt_q == HO_W'(HOLDOFF - 1)) begin
                    state_d = ST_NORMAL;
                end else begin
                    ho_cnt_d = ho_cnt_q + 1'b1;
                end
            end
            default: state_d = ST_NORMAL;
        endcase
    end

    // DO follows the next state so the safe pattern lands on the same edge as the trip.
    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            di_meta_q <= '0;
            di_sync_q <= '0;
            di_filt_q <= '0;
            il_meta_q <= '0;
            il_sync_q <= '0;
            il_filt_q <= '0;
            for (int i = 0; i < DI_W; i++) di_cnt_q[i] <= '0;
            for (int i = 0; i < IL_W; i++) il_cnt_q[i] <= '0;
            latch_q   <= '0;
            state_q   <= ST_NORMAL;
            ho_cnt_q  <= '0;
            do_q      <= '0;
            tripped_q <= 1'b0;
        end else begin
            di_meta_q <= i_di;
            di_sync_q <= di_meta_q;
            di_filt_q <= di_filt_d;
            il_meta_q <= i_interlock;
            il_sync_q <= il_meta_q;
            il_filt_q <= il_filt_d;
            for (int i = 0; i < DI_W; i++) di_cnt_q[i] <= di_cnt_d[i];
            for (int i = 0; i < IL_W; i++) il_cnt_q[i] <= il_cnt_d[i];
            latch_q   <= latch_d;
            state_q   <= state_d;
            ho_cnt_q  <= ho_cnt_d;
            do_q      <= (state_d == ST_NORMAL) ? i_do : i_safe_do;
            tripped_q <= (state_d != ST_NORMAL);
        end
    end

    assign o_di       = di_filt_q;
    assign o_do       = do_q;
    assign o_il_latch = latch_q;
    assign o_il_state = state_q;
    assign o_tripped  = tripped_q;

endmodule

// File: tb/tb_dio_interlock_ctrl.sv
// Bench for dio_interlock_ctrl: directed trip/clear/recover scenarios followed by
// random I/O activity, all checked against a pin-history reference model.
module tb_dio_interlock_ctrl;

    localparam int HOLDOFF = 4;

    logic        clk;
    logic        rstN;
    logic [7:0]  di, il, mask, doSw, safeDo;
    logic [15:0] debCnt;
    logic        ilClr;

    logic [7:0]  oDi, oDo, oLatch;
    logic [1:0]  oState;
    logic        oTripped;

    int checks = 0;
    int errors = 0;

    // Reference model: filtered values, latch, state (0 normal, 1 tripped, 2 recover).
    logic [7:0] mDi, mIl, mLatch, mDo;
    int         mState, mCyc;
    logic [7:0] diHist [64];
    logic [7:0] ilHist [64];
    int         edgeN;

    dio_interlock_ctrl #(
        .DI_W(8), .DO_W(8), .IL_W(8), .DEB_W(16), .HOLDOFF(HOLDOFF)
    ) dut (
        .s00_axi_aclk   (clk),
        .s00_axi_aresetn(rstN),
        .i_di           (di),
        .i_interlock    (il),
        .i_deb_cnt      (debCnt),
        .i_il_mask      (mask),
        .i_do           (doSw),
        .i_safe_do      (safeDo),
        .i_il_clr       (ilClr),
        .o_di           (oDi),
        .o_do           (oDo),
        .o_il_latch     (oLatch),
        .o_il_state     (oState),
        .o_tripped      (oTripped)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    function automatic void modelReset();
        mDi = '0; mIl = '0; mLatch = '0; mDo = '0;
        mState = 0; mCyc = 0; edgeN = 64;
        for (int k = 0; k < 64; k++) begin
            diHist[k] = '0;
            ilHist[k] = '0;
        end
    endfunction

    // A filtered bit flips once the synchronised pin (pin two edges ago) has shown
    // the opposite value on each of the last d edges.
    function automatic logic [7:0] settle(input logic [7:0] filt, input bit useIl, input int d);
        logic [7:0] res;
        logic [7:0] s;
        bit         allOpp;
        res = filt;
        for (int b = 0; b < 8; b++) begin
            allOpp = 1'b1;
            for (int j = 0; j < d; j++) begin
                s = useIl ? ilHist[(edgeN - 2 - j) % 64] : diHist[(edgeN - 2 - j) % 64];
                if (s[b] == filt[b]) allOpp = 1'b0;
            end
            if (allOpp) res[b] = ~filt[b];
        end
        return res;
    endfunction

    function automatic void modelEdge();
        logic [7:0] act, newDi, newIl;
        int d;
        if (!rstN) begin
            modelReset();
            return;
        end
        act   = mIl & mask;
        d     = (debCnt == 0) ? 1 : int'(debCnt);
        newDi = settle(mDi, 1'b0, d);
        newIl = settle(mIl, 1'b1, d);
        mLatch = ilClr ? act : (mLatch | act);
        case (mState)
            0: if (act != 0) mState = 1;
            1: if (ilClr && act == 0) begin mState = 2; mCyc = 0; end
            default: begin
                if (act != 0) mState = 1;
                else if (mCyc == HOLDOFF - 1) mState = 0;
                else mCyc++;
            end
        endcase
        mDo = (mState == 0) ? doSw : safeDo;
        diHist[edgeN % 64] = di;
        ilHist[edgeN % 64] = il;
        edgeN++;
        mDi = newDi;
        mIl = newIl;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic compareAll();
        logic [1:0] st;
        st = mState[1:0];
        checkOutput("o_di", 32'(oDi), 32'(mDi));
        checkOutput("o_do", 32'(oDo), 32'(mDo));
        checkOutput("o_il_latch", 32'(oLatch), 32'(mLatch));
        checkOutput("o_il_state", 32'(oState), 32'(st));
        checkOutput("o_tripped", 32'(oTripped), 32'(mState != 0));
    endtask

    task automatic tick();
        @(posedge clk);
        modelEdge();
        @(negedge clk);
        compareAll();
    endtask

    task automatic applyStimulus();
        int b;
        if ($urandom_range(0, 5) == 0) begin
            b = $urandom_range(0, 7);
            di[b] = ~di[b];
        end
        if ($urandom_range(0, 11) == 0) begin
            b = $urandom_range(0, 7);
            il[b] = ~il[b];
        end
        if ($urandom_range(0, 49) == 0) debCnt = 16'($urandom_range(0, 3));
        if ($urandom_range(0, 39) == 0) mask = 8'($urandom);
        doSw   = 8'($urandom);
        safeDo = 8'($urandom);
        ilClr  = ($urandom_range(0, 5) == 0);
    endtask

    initial begin
        rstN = 1'b1; di = '0; il = '0; mask = '0;
        doSw = 8'hA5; safeDo = '0; debCnt = 16'd4; ilClr = 1'b0;
        modelReset();
        #1 rstN = 1'b0;
        modelReset();
        repeat (3) tick();
        checkOutput("reset_do", 32'(oDo), 32'h0);
        checkOutput("reset_state", 32'(oState), 32'h0);

        // Reset release with software DO
        rstN = 1'b1;
        tick();
        checkOutput("t1_do", 32'(oDo), 32'hA5);
        checkOutput("t1_state", 32'(oState), 32'h0);
        checkOutput("t1_di", 32'(oDi), 32'h0);

        // Glitch rejection and debounce latency
        di = 8'h08;
        repeat (3) tick();
        di = 8'h00;
        repeat (8) tick();
        checkOutput("t2_glitch", 32'(oDi[3]), 32'h0);
        di = 8'h08;
        repeat (5) tick();
        checkOutput("t2_d4_edge5", 32'(oDi[3]), 32'h0);
        tick();
        checkOutput("t2_d4_edge6", 32'(oDi[3]), 32'h1);
        di = 8'h00;
        repeat (8) tick();
        debCnt = 16'd0;
        di = 8'h08;
        repeat (2) tick();
        checkOutput("t2_d0_edge2", 32'(oDi[3]), 32'h0);
        tick();
        checkOutput("t2_d0_edge3", 32'(oDi[3]), 32'h1);

        // Interlock trip
        debCnt = 16'd1; mask = 8'h01; safeDo = 8'h0F; il = 8'h01;
        repeat (3) tick();
        checkOutput("t3_edge3_state", 32'(oState), 32'h0);
        checkOutput("t3_edge3_do", 32'(oDo), 32'hA5);
        tick();
        checkOutput("t3_state", 32'(oState), 32'h1);
        checkOutput("t3_do", 32'(oDo), 32'h0F);
        checkOutput("t3_latch", 32'(oLatch), 32'h01);
        checkOutput("t3_tripped", 32'(oTripped), 32'h1);

        // Clear ignored while active, then clear and recover
        ilClr = 1'b1;
        tick();
        ilClr = 1'b0;
        checkOutput("t4_clr_ignored", 32'(oState), 32'h1);
        il = 8'h00;
        repeat (4) tick();
        checkOutput("t4_still_tripped", 32'(oState), 32'h1);
        ilClr = 1'b1;
        tick();
        ilClr = 1'b0;
        checkOutput("t4_recover", 32'(oState), 32'h2);
        checkOutput("t4_latch_cleared", 32'(oLatch), 32'h0);
        checkOutput("t4_do_safe", 32'(oDo), 32'h0F);
        repeat (3) tick();
        checkOutput("t4_holdoff_3", 32'(oState), 32'h2);
        tick();
        checkOutput("t4_normal", 32'(oState), 32'h0);
        checkOutput("t4_do_back", 32'(oDo), 32'hA5);
        checkOutput("t4_tripped_low", 32'(oTripped), 32'h0);

        // Re-trip from RECOVER
        mask = 8'h03; il = 8'h01;
        repeat (4) tick();
        checkOutput("t5_trip", 32'(oState), 32'h1);
        il = 8'h00;
        repeat (4) tick();
        ilClr = 1'b1; il = 8'h02;
        tick();
        ilClr = 1'b0;
        checkOutput("t5_recover", 32'(oState), 32'h2);
        repeat (2) tick();
        checkOutput("t5_still_recover", 32'(oState), 32'h2);
        tick();
        checkOutput("t5_retrip", 32'(oState), 32'h1);
        checkOutput("t5_latch", 32'(oLatch), 32'h02);
        checkOutput("t5_do", 32'(oDo), 32'h0F);

        // Masked-out channel, mask enable on active channel, async reset
        il = 8'h00;
        repeat (4) tick();
        ilClr = 1'b1;
        tick();
        ilClr = 1'b0;
        repeat (4) tick();
        checkOutput("t6_normal", 32'(oState), 32'h0);
        il = 8'h20;
        repeat (6) tick();
        checkOutput("t6_masked_state", 32'(oState), 32'h0);
        checkOutput("t6_masked_latch", 32'(oLatch), 32'h0);
        mask = 8'h23;
        tick();
        checkOutput("t6_unmask_trip", 32'(oState), 32'h1);
        checkOutput("t6_unmask_latch", 32'(oLatch), 32'h20);
        #2 rstN = 1'b0;
        modelReset();
        #1;
        checkOutput("t6_rst_do", 32'(oDo), 32'h0);
        checkOutput("t6_rst_state", 32'(oState), 32'h0);
        checkOutput("t6_rst_latch", 32'(oLatch), 32'h0);
        checkOutput("t6_rst_tripped", 32'(oTripped), 32'h0);
        checkOutput("t6_rst_di", 32'(oDi), 32'h0);
        repeat (2) tick();

        // Random activity against the model
        rstN = 1'b1;
        il = '0; di = '0; mask = 8'hFF; debCnt = 16'd2;
        for (int n = 0; n < 800; n++) begin
            applyStimulus();
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
